// File: rtl/uart_rx_oversampler_pkg.sv
// Shared state encoding, oversampling constants and the 3-sample majority vote
// used by the UART receive front end.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int OS_RATE  = 16;
  localparam int SAMPLE_A = 7;
  localparam int SAMPLE_B = 8;
  localparam int SAMPLE_C = 9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_oversampler_if.sv
// Received-word handshake bundle: the receiver is master (drives word, flags, valid),
// the host-side consumer is slave (drives ready).
interface uart_rx_oversampler_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_oversampler_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; presets to the idle level (1).
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART receive front end: 16x oversampled deframer with 3-sample majority vote,
// parity/framing/overrun flags and a valid/ready word output.
module uart_rx_oversampler
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick_i,
  input  logic                  rx_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  output logic                  busy_o,
  uart_rx_oversampler_if.master rx_if
);

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_START  = 3'(START);
  localparam logic [2:0] ST_DATA   = 3'(DATA);
  localparam logic [2:0] ST_PARITY = 3'(PARITY);
  localparam logic [2:0] ST_STOP   = 3'(STOP);
  localparam logic [3:0] CNT_A     = 4'(SAMPLE_A);
  localparam logic [3:0] CNT_B     = 4'(SAMPLE_B);
  localparam logic [3:0] CNT_C     = 4'(SAMPLE_C);
  localparam logic [3:0] CNT_WRAP  = 4'(OS_RATE - 1);
  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 bit_val_s, mid_s, wrap_s, done_s;
  logic [2:0]           state_q, state_d;
  logic [3:0]           os_cnt_q, os_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d, par_odd_q, par_odd_d, perr_q, perr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d, overrun_q, overrun_d;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (rx_i),
    .sync_o  (rx_s)
  );

  // Third vote comes straight from the line on the os_cnt==9 tick.
  assign bit_val_s = maj3(samp_q[1], samp_q[0], rx_s);
  assign mid_s     = (os_cnt_q == CNT_C);
  assign wrap_s    = (os_cnt_q == CNT_WRAP);

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_idx_d = bit_idx_q;
    samp_d    = samp_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    perr_d    = perr_q;
    done_s    = 1'b0;
    if (sample_tick_i) begin
      os_cnt_d = os_cnt_q + 4'd1;
      if (os_cnt_q == CNT_A) begin
        samp_d[1] = rx_s;
      end else if (os_cnt_q == CNT_B) begin
        samp_d[0] = rx_s;
      end else begin
        samp_d = samp_q;
      end
      case (state_q)
        ST_IDLE: begin
          os_cnt_d = 4'd0;
          if (!rx_s) begin
            state_d   = ST_START;
            par_en_d  = parity_en_i;
            par_odd_d = parity_odd_i;
            perr_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (mid_s && bit_val_s) begin
            state_d  = ST_IDLE;
            os_cnt_d = 4'd0;
          end else if (wrap_s) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_START;
          end
        end
        ST_DATA: begin
          if (mid_s) begin
            shift_d = {bit_val_s, shift_q[DATA_BITS-1:1]};
          end else begin
            shift_d = shift_q;
          end
          if (wrap_s && (bit_idx_q == LAST_IDX)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else if (wrap_s) begin
            bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            bit_idx_d = bit_idx_q;
          end
        end
        ST_PARITY: begin
          if (mid_s) begin
            perr_d = ((^shift_q) ^ bit_val_s) != par_odd_q;
          end else begin
            perr_d = perr_q;
          end
          if (wrap_s) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_PARITY;
          end
        end
        ST_STOP: begin
          // Leave mid-stop so a following start edge is caught without delay.
          if (mid_s) begin
            state_d  = ST_IDLE;
            os_cnt_d = 4'd0;
            done_s   = 1'b1;
          end else begin
            state_d = ST_STOP;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          os_cnt_d = 4'd0;
        end
      endcase
    end else begin
      os_cnt_d = os_cnt_q;
    end
  end

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    if (done_s) begin
      rx_data_d    = shift_q;
      rx_valid_d   = 1'b1;
      frame_err_d  = ~bit_val_s;
      parity_err_d = perr_q & par_en_q;
      overrun_d    = rx_valid_q & ~rx_if.rx_ready;
    end else if (rx_valid_q && rx_if.rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      os_cnt_q  <= 4'd0;
      bit_idx_q <= 3'd0;
      samp_q    <= 2'b11;
      shift_q   <= {DATA_BITS{1'b0}};
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      samp_q    <= samp_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      perr_q    <= perr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q    <= {DATA_BITS{1'b0}};
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_if.rx_data    = rx_data_q;
  assign rx_if.rx_valid   = rx_valid_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.overrun    = overrun_q;
  assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Self-checking bench for uart_rx_oversampler: directed vector table, hand-written
// corner sequences and randomized frames checked against a frame-level model.
module tb_uart_rx_oversampler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic rx = 1'b1;
  logic parity_en = 1'b0;
  logic parity_odd = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   ovr_cnt = 0;
  int   ph = 0;

  uart_rx_oversampler_if #(.DATA_BITS(8)) rif ();

  uart_rx_oversampler #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick_i (tick),
    .rx_i          (rx),
    .parity_en_i   (parity_en),
    .parity_odd_i  (parity_odd),
    .busy_o        (busy),
    .rx_if         (rif)
  );

  always #5 clk = ~clk;

  // sample_tick every 4th clock
  initial begin
    forever begin
      @(negedge clk);
      tick = (ph == 0);
      ph = (ph + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (rif.overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    bit pen, podd, pflip, stopb, glitch;
    logic [7:0] exp_data;
    bit exp_ferr, exp_perr;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(logic [7:0] d, bit pen, bit podd, bit pflip, bit stopb,
                              bit glitch, logic [7:0] ed, bit ef, bit ep);
    vec_t v;
    v.data = d; v.pen = pen; v.podd = podd; v.pflip = pflip; v.stopb = stopb;
    v.glitch = glitch; v.exp_data = ed; v.exp_ferr = ef; v.exp_perr = ep;
    return v;
  endfunction

  // Parity bit a correct transmitter sends: makes the total count of ones even/odd.
  function automatic bit tx_pbit(logic [7:0] d, bit podd);
    return bit'(($countones(d) % 2) ^ int'(podd));
  endfunction

  function automatic bit model_perr(logic [7:0] d, bit pen, bit podd, bit pflip);
    bit p;
    p = tx_pbit(d, podd) ^ pflip;
    return pen && ((($countones(d) + int'(p)) % 2) != int'(podd));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One bit period (16 ticks = 64 clks); optional middle-sample glitch and a
  // ready pulse landing on the clock edge that completes a stop bit.
  task automatic drive_bit(input bit b, input bit glitch, input bit rdy);
    rx = b;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 36 && glitch) rx = ~b;
      if (k == 40) rx = b;
      if (k == 43 && rdy) rif.rx_ready = 1'b1;
      if (k == 44 && rdy) rif.rx_ready = 1'b0;
    end
  endtask

  task automatic align_tick();
    do @(posedge clk); while (tick !== 1'b1);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd, input bit pflip,
                            input bit stopb, input bit glitch, input bit rdy);
    parity_en = pen;
    parity_odd = podd;
    align_tick();
    drive_bit(1'b0, 1'b0, 1'b0);
    parity_en = ($urandom_range(0, 1) == 1);
    parity_odd = ($urandom_range(0, 1) == 1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], glitch, 1'b0);
    if (pen) drive_bit(tx_pbit(d, podd) ^ pflip, 1'b0, 1'b0);
    drive_bit(stopb, 1'b0, rdy);
    drive_bit(1'b1, 1'b0, 1'b0);
  endtask

  task automatic accept(input string name);
    rif.rx_ready = 1'b1;
    @(negedge clk);
    rif.rx_ready = 1'b0;
    @(negedge clk);
    chk({name, "_accepted"}, 32'(rif.rx_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] tmp;
    logic [7:0] d;
    bit pen, podd, pflip, stopb, glitch, rdy;
    bit m_valid;
    int ovr_base;
    int m_ovr;

    vecs[0] = mk(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    vecs[1] = mk(8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b0);
    vecs[2] = mk(8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b1);
    vecs[3] = mk(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0);
    vecs[4] = mk(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    vecs[5] = mk(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
    vecs[6] = mk(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);

    rif.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(rif.rx_valid), 32'd0);
    chk("reset_data", 32'(rif.rx_data), 32'd0);
    chk("reset_ferr", 32'(rif.frame_err), 32'd0);
    chk("reset_perr", 32'(rif.parity_err), 32'd0);
    chk("reset_overrun", 32'(rif.overrun), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      ovr_base = ovr_cnt;
      send_frame(vecs[i].data, vecs[i].pen, vecs[i].podd, vecs[i].pflip,
                 vecs[i].stopb, vecs[i].glitch, 1'b0);
      chk($sformatf("vec%0d_valid", i), 32'(rif.rx_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(rif.rx_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_ferr", i), 32'(rif.frame_err), 32'(vecs[i].exp_ferr));
      chk($sformatf("vec%0d_perr", i), 32'(rif.parity_err), 32'(vecs[i].exp_perr));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_ovr", i), 32'(ovr_cnt - ovr_base), 32'd0);
      repeat (40) @(negedge clk);
      chk($sformatf("vec%0d_held", i), 32'(rif.rx_valid), 32'd1);
      accept($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_flag_kept", i), 32'(rif.frame_err), 32'(vecs[i].exp_ferr));
    end

    // Short start-bit glitch: rejected by the mid-bit vote.
    align_tick();
    rx = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_busy_in", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (36) @(negedge clk);
    chk("glitch_busy_out", 32'(busy), 32'd0);
    repeat (64) @(negedge clk);
    chk("glitch_no_valid", 32'(rif.rx_valid), 32'd0);

    // Overrun: second word completes while the first is still pending.
    ovr_base = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovr_first_data", 32'(rif.rx_data), 32'h11);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovr_pulse_count", 32'(ovr_cnt - ovr_base), 32'd1);
    chk("ovr_new_data", 32'(rif.rx_data), 32'h22);
    chk("ovr_valid", 32'(rif.rx_valid), 32'd1);
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("accept_at_done_ovr", 32'(ovr_cnt - ovr_base), 32'd1);
    chk("accept_at_done_valid", 32'(rif.rx_valid), 32'd1);
    chk("accept_at_done_data", 32'(rif.rx_data), 32'h33);

    // Reset during data bit 4 of 0x99 with an old word still pending.
    tmp = 8'h99;
    parity_en = 1'b0;
    align_tick();
    drive_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(tmp[i], 1'b0, 1'b0);
    rx = tmp[4];
    repeat (20) @(negedge clk);
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rx = 1'b1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(rif.rx_valid), 32'd0);
    chk("rst_mid_data", 32'(rif.rx_data), 32'd0);
    chk("rst_mid_ferr", 32'(rif.frame_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (256) @(negedge clk);
    chk("rst_mid_no_valid", 32'(rif.rx_valid), 32'd0);
    send_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("after_rst_valid", 32'(rif.rx_valid), 32'd1);
    chk("after_rst_data", 32'(rif.rx_data), 32'h66);
    chk("after_rst_ferr", 32'(rif.frame_err), 32'd0);
    accept("after_rst");

    // Randomized frames against the frame-level scoreboard.
    m_valid = 1'b0;
    m_ovr = ovr_cnt;
    for (int n = 0; n < 30; n++) begin
      d      = 8'($urandom_range(0, 255));
      pen    = ($urandom_range(0, 1) == 1);
      podd   = ($urandom_range(0, 1) == 1);
      pflip  = ($urandom_range(0, 3) == 0);
      stopb  = ($urandom_range(0, 4) != 0);
      glitch = ($urandom_range(0, 2) == 0);
      rdy    = ($urandom_range(0, 3) == 0);
      if (m_valid && ($urandom_range(0, 1) == 1)) begin
        accept($sformatf("rnd%0d_pre", n));
        m_valid = 1'b0;
      end
      send_frame(d, pen, podd, pflip, stopb, glitch, rdy);
      if (m_valid && !rdy) m_ovr++;
      m_valid = 1'b1;
      chk($sformatf("rnd%0d_valid", n), 32'(rif.rx_valid), 32'(m_valid));
      chk($sformatf("rnd%0d_data", n), 32'(rif.rx_data), 32'(d));
      chk($sformatf("rnd%0d_ferr", n), 32'(rif.frame_err), 32'(!stopb));
      chk($sformatf("rnd%0d_perr", n), 32'(rif.parity_err),
          32'(model_perr(d, pen, podd, pflip)));
      chk($sformatf("rnd%0d_ovr", n), 32'(ovr_cnt), 32'(m_ovr));
      chk($sformatf("rnd%0d_busy", n), 32'(busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
